// File: rtl/alu_mul.sv
// -----------------------------------------------------------------------------
// alu_mul -- iterative 32x32 integer multiplier for the ALU datapath (MUL/MULS)
//
// Forms the low WIDTH bits of In1*In2 with a shift-add engine that retires one
// multiplier bit per cycle. It also produces an updated {N,Z,C,V} flag nibble.
// A start edge captures the operands. Result/New_Flag update on the edge that
// raises done, which is 33 edges after the start edge. Result and New_Flag
// then hold until the next completion.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (aborts a running multiply)
//   start     in   request a multiply; sampled only while idle
//   In1       in   [WIDTH-1:0] multiplicand
//   In2       in   [WIDTH-1:0] multiplier
//   S         in   1 = update N/Z from the result, 0 = pass Flag through
//   Flag      in   [3:0] current flags {N,Z,C,V}
//   Result    out  [WIDTH-1:0] low WIDTH bits of the product
//   New_Flag  out  [3:0] updated flags {N,Z,C,V}
//   busy      out  high while a multiply is in progress
//   done      out  one-cycle pulse when Result/New_Flag have been updated
//
// Build option:
//   MUL_OVF_FLAGS_EN -- when defined and S=1, C reports a non-zero unsigned
//   high word and V reports signed 32-bit overflow. When undefined, C and V
//   always pass through and no high-word flag logic is built.
// -----------------------------------------------------------------------------
module alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             S,
    input  logic [3:0]       Flag,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       New_Flag,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   acc;       // running product
    logic [2*WIDTH-1:0]   mcand;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]     mplier;    // multiplier, shifted right each step
    logic [CNT_W-1:0]     cnt;       // iterations still to run
    logic                 s_q;
    logic [3:0]           flag_q;
    logic [3:0]           flag_new;
    logic                 finish;

`ifdef MUL_OVF_FLAGS_EN
    // The shift registers destroy the operands, so the signed high-word
    // correction needs its own copies.
    logic [WIDTH-1:0]     in1_q, in2_q;
    logic [WIDTH-1:0]     hi_s;
`endif

    // All iterations retired: this edge writes the result and pulses done.
    assign finish = (state == BUSY) && (cnt == '0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- FSM: next state / outputs ----------------
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        state_next = state;
        busy       = 1'b0;
        if (state == IDLE) begin
            if (start) state_next = BUSY;
        end else begin
            busy = 1'b1;
            if (finish) state_next = IDLE;
        end
    end

    // ---------------- flag computation on the final accumulator ----------------
    always_comb begin
        flag_new = flag_q;
`ifdef MUL_OVF_FLAGS_EN
        // Signed high word = unsigned high word minus the cross terms
        // contributed by each negative operand (mod 2^WIDTH).
        hi_s = acc[2*WIDTH-1:WIDTH]
             - (in1_q[WIDTH-1] ? in2_q : '0)
             - (in2_q[WIDTH-1] ? in1_q : '0);
`endif
        if (s_q) begin
            flag_new[3] = acc[WIDTH-1];
            flag_new[2] = (acc[WIDTH-1:0] == '0);
`ifdef MUL_OVF_FLAGS_EN
            flag_new[1] = |acc[2*WIDTH-1:WIDTH];
            flag_new[0] = (hi_s != {WIDTH{acc[WIDTH-1]}});
`endif
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        // NOTE: every datapath register is reset. Reset must clear the
        // accumulators and the visible Result/New_Flag, not just the control.
        if (rst) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            s_q      <= 1'b0;
            flag_q   <= '0;
            Result   <= '0;
            New_Flag <= '0;
            done     <= 1'b0;
`ifdef MUL_OVF_FLAGS_EN
            in1_q    <= '0;
            in2_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, In1};
                    mplier <= In2;
                    cnt    <= CNT_W'(WIDTH);
                    s_q    <= S;
                    flag_q <= Flag;
`ifdef MUL_OVF_FLAGS_EN
                    in1_q  <= In1;
                    in2_q  <= In2;
`endif
                end
            end else if (finish) begin
                Result   <= acc[WIDTH-1:0];
                New_Flag <= flag_new;
                done     <= 1'b1;
            end else begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_mul.sv
// -----------------------------------------------------------------------------
// tb_alu_mul -- directed self-checking bench for alu_mul.
// Each step launches one multiply and checks busy, the done latency (33 edges),
// Result, New_Flag and the one-cycle done pulse against hand-computed values.
// Control steps cover: an ignored mid-operation start, a reset abort at
// iteration 10, and back-to-back starts in the done cycle.
// Outputs are sampled on the falling edge; inputs are driven there as well.
// -----------------------------------------------------------------------------
module tb_alu_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] In1, In2;
    logic        S;
    logic [3:0]  Flag;
    logic [31:0] Result;
    logic [3:0]  New_Flag;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    alu_mul #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .In1      (In1),
        .In2      (In2),
        .S        (S),
        .Flag     (Flag),
        .Result   (Result),
        .New_Flag (New_Flag),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: raises start for exactly one rising edge (E0).
    // It then scrambles the inputs to prove that the captured copies are used.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [3:0] f);
        In1 = a; In2 = b; S = s; Flag = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        In1 = $urandom; In2 = $urandom; S = ~s; Flag = ~f;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    // Counts rising edges after E0 until done is seen (bounded). It checks the
    // 33-edge latency and the results, and returns at the falling edge where
    // done is high.
    task automatic wait_done(input string tag, input int edges_before,
                             input logic [31:0] exp_r, input logic [3:0] exp_f);
        int edges = edges_before;
        while (done !== 1'b1 && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_result"},  {32'd0, Result}, {32'd0, exp_r});
        check({tag, "_flags"},   {60'd0, New_Flag}, {60'd0, exp_f});
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    // Counts done pulses over n cycles. Used where no completion may appear.
    task automatic expect_quiet(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check({tag, "_no_done"}, 64'(pulses), 64'd0);
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    logic [3:0] ovf_flags;

    initial begin
`ifdef MUL_OVF_FLAGS_EN
        ovf_flags = 4'b1010;
`else
        ovf_flags = 4'b1011;
`endif
        rst = 1'b1; start = 1'b0; In1 = '0; In2 = '0; S = 1'b0; Flag = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   {63'd0, busy}, 64'd0);
        check("reset_done",   {63'd0, done}, 64'd0);
        check("reset_result", {32'd0, Result}, 64'd0);
        check("reset_flags",  {60'd0, New_Flag}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 2*3 with flags passed through; also checks the done pulse width.
        start_op(32'd2, 32'd3, 1'b0, 4'b0000);
        wait_done("mul_2x3", 0, 32'd6, 4'b0000);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Negative result sets N.
        start_op(32'd1, 32'hFFFF_FFFD, 1'b1, 4'b0000);
        wait_done("neg", 0, 32'hFFFF_FFFD, 4'b1000);

        // Back-to-back start in the done cycle: (-6)*(-2), flags held.
        start_op(32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0, 4'b0000);
        wait_done("pass", 0, 32'd12, 4'b0000);

        // Overflow case; C/V behaviour depends on the build option.
        start_op(32'hFFFF_FFFF, 32'd9, 1'b1, 4'b0011);
        wait_done("ovf", 0, 32'hFFFF_FFF7, ovf_flags);

        // Zero result sets Z; then a plain positive result clears N/Z.
        start_op(32'd0, 32'd0, 1'b1, 4'b0000);
        wait_done("zero", 0, 32'd0, 4'b0100);
        start_op(32'd10, 32'd10, 1'b1, 4'b0000);
        wait_done("ten_sq", 0, 32'd100, 4'b0000);
        @(negedge clk);

        // start re-asserted mid-operation is ignored: one done only, original operands.
        start_op(32'd3, 32'd5, 1'b1, 4'b0000);
        repeat (4) @(negedge clk);
        In1 = 32'd100; In2 = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("mid_start", 5, 32'd15, 4'b0000);
        expect_quiet("mid_start", 40);

        // Reset at iteration 10 aborts with no done pulse.
        start_op(32'd7, 32'd7, 1'b1, 4'b0000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",   {63'd0, busy}, 64'd0);
        check("abort_done",   {63'd0, done}, 64'd0);
        check("abort_result", {32'd0, Result}, 64'd0);
        check("abort_flags",  {60'd0, New_Flag}, 64'd0);
        expect_quiet("abort", 40);

        // A fresh start after the abort completes normally.
        start_op(32'd7, 32'd6, 1'b1, 4'b0000);
        wait_done("after_abort", 0, 32'd42, 4'b0000);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mul.md
Name: alu_mul

Overview:
- 32x32 integer multiplier for the ALU datapath (MUL/MULS).
- Produces the low 32 bits of the product and an updated ARM-style flag nibble {N,Z,C,V}.
- Iterative shift-add engine, one bit per cycle, with a start/busy/done handshake.
- Sits beside the ADD unit; the ALU result mux selects Result and New_Flag when done is high.

Parameters:
- WIDTH, 32, operand/result width; 32 is the only width verified.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when idle.
- In1  input  32  multiplicand.
- In2  input  32  multiplier.
- S  input  1  set-flags: 1 = update flags from the result, 0 = pass Flag through.
- Flag  input  4  current flags [3]=N, [2]=Z, [1]=C, [0]=V.
- Result  output  32  low 32 bits of In1*In2.
- New_Flag  output  4  updated flags, same bit order as Flag.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; Result/New_Flag valid and updated.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state IDLE, Result=0, New_Flag=0000, busy=0, done=0, internal accumulators cleared. Reset overrides start. Reset during BUSY aborts the operation and produces no done pulse.
- States: IDLE and BUSY.
- IDLE -> BUSY when start=1 at an edge (edge E0):
  - capture In1, In2, S and Flag;
  - clear the 64-bit accumulator;
  - load the iteration counter with 32;
  - busy=1 from E0.
- BUSY, each edge: if the current multiplier LSB is 1, add the shifted multiplicand to the accumulator; shift the multiplicand left and the multiplier right; decrement the counter.
- After 32 iterations, at edge E33:
  - Result <= accumulator[31:0];
  - New_Flag computed as below;
  - done=1 for exactly one cycle; busy=0; return to IDLE.
  - Total latency: 33 edges from the start edge.
- start while BUSY: ignored. Operands, S and Flag changing while BUSY: no effect (captured copies are used).
- start=1 in the cycle done is high is accepted; the unit is IDLE then.
- Result and New_Flag hold their last values between operations.
- Arithmetic:
  - The unsigned 64-bit product is formed.
  - Result is the low 32 bits, which are identical for signed and unsigned interpretation, so no signedness input exists.
  - 0xFFFFFFFF is treated as -1 or 4294967295 only for flag purposes.
- Flags with S=1: N = Result[31]; Z = (Result == 0); C and V = captured Flag[1], Flag[0] (unchanged).
- Flags with S=0: New_Flag = captured Flag unchanged.

Optional Feature:
- Macro MUL_OVF_FLAGS_EN.
- Defined, S=1:
  - C = 1 when the unsigned 64-bit product[63:32] != 0;
  - V = 1 when the signed 64-bit product does not fit in 32-bit signed, i.e. the signed high word != {32{Result[31]}}.
  - Signed high word = unsigned high word - (In1[31] ? In2 : 0) - (In2[31] ? In1 : 0), modulo 2^32.
- Defined, S=0: pass-through, as in the base design.
- Not defined: C and V preserved as in the base design; no high-word logic is synthesized.

Test Plan:
- Unsigned, flags held: In1=2, In2=3, S=0, Flag=0000, start pulse -> done on edge 33, Result=6, New_Flag=0000.
- Negative result: In1=1, In2=0xFFFFFFFD (-3), S=1, Flag=0000 -> Result=0xFFFFFFFD, New_Flag=1000.
- Pass-through: In1=0xFFFFFFFA (-6), In2=0xFFFFFFFE (-2), S=0, Flag=0000 -> Result=12, New_Flag=0000.
- Overflow case: In1=0xFFFFFFFF, In2=9, S=1, Flag=0011 -> Result=0xFFFFFFF7.
  - Without macro: New_Flag=1011.
  - With MUL_OVF_FLAGS_EN (unsigned high=8, signed -9 fits): New_Flag=1010.
- Zero and positive: In1=0, In2=0, S=1, Flag=0000 -> Result=0, New_Flag=0100. Then In1=10, In2=10, S=1 -> Result=100, New_Flag=0000.
- Control:
  - start re-asserted mid-operation -> ignored, one done only.
  - rst=1 at iteration 10 -> next cycle busy=0, done=0, Result=0, New_Flag=0000; a fresh start then completes normally.
